// File: rtl/usr_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one fpga_core user TX header/payload
// input between NUM_PORTS requesters. A grant is held from header accept to payload tlast.
module usr_tx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int HDR_WIDTH  = 112,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*HDR_WIDTH-1:0]   s_hdr_data,
  input  logic [NUM_PORTS-1:0]             s_hdr_valid,
  output logic [NUM_PORTS-1:0]             s_hdr_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_payload_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_payload_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_payload_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_payload_axis_tlast,
  input  logic [NUM_PORTS-1:0]             s_payload_axis_tuser,
  output logic [NUM_PORTS-1:0]             s_payload_axis_tready,
  output logic [HDR_WIDTH-1:0]             m_usr_hdr_data,
  output logic                             m_usr_hdr_valid,
  input  logic                             m_usr_hdr_ready,
  output logic [DATA_WIDTH-1:0]            m_usr_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_usr_payload_axis_tkeep,
  output logic                             m_usr_payload_axis_tvalid,
  output logic                             m_usr_payload_axis_tlast,
  output logic                             m_usr_payload_axis_tuser,
  input  logic                             m_usr_payload_axis_tready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             busy
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [NUM_PORTS-1:0] grant_next;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_next;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 sel_hdr_valid;
  logic                 sel_payload_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  // Search upward from rr_ptr, wrapping, for the first requester with a header pending.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick_valid && s_hdr_valid[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
      end
    end
  end

  // One-hot AND-OR mux off the registered grant; everything reads 0 while grant is 0.
  always_comb begin
    m_usr_hdr_data           = '0;
    m_usr_payload_axis_tdata = '0;
    m_usr_payload_axis_tkeep = '0;
    m_usr_payload_axis_tlast = 1'b0;
    m_usr_payload_axis_tuser = 1'b0;
    sel_hdr_valid            = 1'b0;
    sel_payload_valid        = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        m_usr_hdr_data           = m_usr_hdr_data | s_hdr_data[i*HDR_WIDTH +: HDR_WIDTH];
        m_usr_payload_axis_tdata = m_usr_payload_axis_tdata | s_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_usr_payload_axis_tkeep = m_usr_payload_axis_tkeep | s_payload_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_usr_payload_axis_tlast = m_usr_payload_axis_tlast | s_payload_axis_tlast[i];
        m_usr_payload_axis_tuser = m_usr_payload_axis_tuser | s_payload_axis_tuser[i];
        sel_hdr_valid            = sel_hdr_valid | s_hdr_valid[i];
        sel_payload_valid        = sel_payload_valid | s_payload_axis_tvalid[i];
      end
    end
  end

  assign m_usr_hdr_valid           = (state == HDR) && sel_hdr_valid;
  assign m_usr_payload_axis_tvalid = (state == PAYLOAD) && sel_payload_valid;
  assign s_hdr_ready           = (state == HDR && m_usr_hdr_ready) ? grant : '0;
  assign s_payload_axis_tready = (state == PAYLOAD && m_usr_payload_axis_tready) ? grant : '0;
  assign busy                  = (state != IDLE);

  // The pointer only advances at end of packet, so a requester keeps priority until served.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_next = NUM_PORTS'(1) << pick_idx;
          state_next = HDR;
        end else begin
          grant_next = '0;
        end
      end
      HDR: begin
        if (m_usr_hdr_valid && m_usr_hdr_ready) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (m_usr_payload_axis_tvalid && m_usr_payload_axis_tready && m_usr_payload_axis_tlast) begin
          rr_ptr_next = PTR_W'((int'(grant_idx) + 1) % NUM_PORTS);
          grant_next  = '0;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_tx_arbiter.sv
// Scoreboard bench for usr_tx_arbiter: directed packets push expected headers/beats,
// a negedge monitor pops and compares them on every downstream handshake.
module tb_usr_tx_arbiter;

  localparam int NP  = 4;
  localparam int HW  = 112;
  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int TMO = 100;

  typedef struct {
    int            port;
    logic [HW-1:0] hdr;
  } hdr_exp_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_exp_t;

  logic             clk;
  logic             rst;
  logic [NP*HW-1:0] s_hdr_data;
  logic [NP-1:0]    s_hdr_valid;
  logic [NP-1:0]    s_hdr_ready;
  logic [NP*DW-1:0] s_payload_axis_tdata;
  logic [NP*KW-1:0] s_payload_axis_tkeep;
  logic [NP-1:0]    s_payload_axis_tvalid;
  logic [NP-1:0]    s_payload_axis_tlast;
  logic [NP-1:0]    s_payload_axis_tuser;
  logic [NP-1:0]    s_payload_axis_tready;
  logic [HW-1:0]    m_usr_hdr_data;
  logic             m_usr_hdr_valid;
  logic             m_usr_hdr_ready;
  logic [DW-1:0]    m_usr_payload_axis_tdata;
  logic [KW-1:0]    m_usr_payload_axis_tkeep;
  logic             m_usr_payload_axis_tvalid;
  logic             m_usr_payload_axis_tlast;
  logic             m_usr_payload_axis_tuser;
  logic             m_usr_payload_axis_tready;
  logic [NP-1:0]    grant;
  logic             busy;

  int n_compared     = 0;
  int n_mismatched   = 0;
  int cyc_cnt        = 0;
  int last_hdr_cyc   = 0;
  int first_beat_cyc = 0;
  bit beat_first     = 1'b0;
  bit bp_toggle      = 1'b0;

  logic [HW-1:0] hdr_tbl  [NP];
  logic [DW-1:0] data_tbl [NP][8];
  logic [KW-1:0] keep_tbl [NP][8];
  logic          user_tbl [NP][8];

  hdr_exp_t  hdr_q  [$];
  beat_exp_t beat_q [$];
  hdr_exp_t  mon_hdr;
  beat_exp_t mon_beat;
  logic [NP-1:0] mon_exp_grant;

  usr_tx_arbiter #(
    .NUM_PORTS (NP),
    .HDR_WIDTH (HW),
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_hdr_data               (s_hdr_data),
    .s_hdr_valid              (s_hdr_valid),
    .s_hdr_ready              (s_hdr_ready),
    .s_payload_axis_tdata     (s_payload_axis_tdata),
    .s_payload_axis_tkeep     (s_payload_axis_tkeep),
    .s_payload_axis_tvalid    (s_payload_axis_tvalid),
    .s_payload_axis_tlast     (s_payload_axis_tlast),
    .s_payload_axis_tuser     (s_payload_axis_tuser),
    .s_payload_axis_tready    (s_payload_axis_tready),
    .m_usr_hdr_data           (m_usr_hdr_data),
    .m_usr_hdr_valid          (m_usr_hdr_valid),
    .m_usr_hdr_ready          (m_usr_hdr_ready),
    .m_usr_payload_axis_tdata (m_usr_payload_axis_tdata),
    .m_usr_payload_axis_tkeep (m_usr_payload_axis_tkeep),
    .m_usr_payload_axis_tvalid(m_usr_payload_axis_tvalid),
    .m_usr_payload_axis_tlast (m_usr_payload_axis_tlast),
    .m_usr_payload_axis_tuser (m_usr_payload_axis_tuser),
    .m_usr_payload_axis_tready(m_usr_payload_axis_tready),
    .grant                    (grant),
    .busy                     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Downstream payload ready: steady high, or toggling every cycle when backpressure is on.
  initial begin
    m_usr_payload_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_usr_payload_axis_tready = bp_toggle ? ~m_usr_payload_axis_tready : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: got %s expected none", name, what);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadPacket(input int p, input logic [HW-1:0] hdr, input logic [DW-1:0] base);
    hdr_tbl[p] = hdr;
    for (int i = 0; i < 8; i++) begin
      data_tbl[p][i] = base + DW'(i);
      keep_tbl[p][i] = 8'hff;
      user_tbl[p][i] = 1'b0;
    end
  endtask

  task automatic expectPacket(input int p, input int nbeats);
    hdr_exp_t  h;
    beat_exp_t b;
    h.port = p;
    h.hdr  = hdr_tbl[p];
    hdr_q.push_back(h);
    for (int i = 0; i < nbeats; i++) begin
      b.port = p;
      b.data = data_tbl[p][i];
      b.keep = keep_tbl[p][i];
      b.last = (i == nbeats - 1);
      b.user = user_tbl[p][i];
      beat_q.push_back(b);
    end
  endtask

  task automatic driveBeat(input int p, input int i, input int nbeats);
    s_payload_axis_tdata[p*DW +: DW] = data_tbl[p][i];
    s_payload_axis_tkeep[p*KW +: KW] = keep_tbl[p][i];
    s_payload_axis_tlast[p]          = (i == nbeats - 1);
    s_payload_axis_tuser[p]          = user_tbl[p][i];
    s_payload_axis_tvalid[p]         = 1'b1;
  endtask

  // Requester model: header and first beat go up together, each held until its handshake.
  task automatic applyStimulus(input int p, input int nbeats);
    int wait_cnt;
    s_hdr_data[p*HW +: HW] = hdr_tbl[p];
    s_hdr_valid[p] = 1'b1;
    driveBeat(p, 0, nbeats);
    wait_cnt = 0;
    @(negedge clk);
    while (!s_hdr_ready[p]) begin
      wait_cnt++;
      if (wait_cnt > TMO) begin
        reportFail("hdr_timeout", "no header ready");
        s_hdr_valid[p] = 1'b0;
        s_payload_axis_tvalid[p] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_hdr_valid[p] = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      driveBeat(p, i, nbeats);
      wait_cnt = 0;
      @(negedge clk);
      while (!s_payload_axis_tready[p]) begin
        wait_cnt++;
        if (wait_cnt > TMO) begin
          reportFail("beat_timeout", "no payload ready");
          s_payload_axis_tvalid[p] = 1'b0;
          return;
        end
        @(negedge clk);
      end
      @(posedge clk);
      #1;
    end
    s_payload_axis_tvalid[p] = 1'b0;
    s_payload_axis_tlast[p]  = 1'b0;
    s_payload_axis_tuser[p]  = 1'b0;
  endtask

  // Monitor: compares every downstream handshake against the scoreboard queues.
  always @(negedge clk) begin
    checkOutput("ready_isolation", {120'd0, s_hdr_ready & ~grant, s_payload_axis_tready & ~grant}, 128'd0);
    if (m_usr_hdr_valid && m_usr_hdr_ready) begin
      if (hdr_q.size() == 0) begin
        reportFail("unexpected_hdr", "extra header");
      end else begin
        mon_hdr = hdr_q.pop_front();
        mon_exp_grant = '0;
        mon_exp_grant[mon_hdr.port] = 1'b1;
        checkOutput("hdr_data", m_usr_hdr_data, mon_hdr.hdr);
        checkOutput("hdr_grant", grant, mon_exp_grant);
      end
      last_hdr_cyc = cyc_cnt;
      beat_first   = 1'b1;
    end
    if (m_usr_payload_axis_tvalid && m_usr_payload_axis_tready) begin
      if (beat_q.size() == 0) begin
        reportFail("unexpected_beat", "extra beat");
      end else begin
        mon_beat = beat_q.pop_front();
        mon_exp_grant = '0;
        mon_exp_grant[mon_beat.port] = 1'b1;
        checkOutput("beat_data", m_usr_payload_axis_tdata, mon_beat.data);
        checkOutput("beat_keep", m_usr_payload_axis_tkeep, mon_beat.keep);
        checkOutput("beat_last", m_usr_payload_axis_tlast, mon_beat.last);
        checkOutput("beat_user", m_usr_payload_axis_tuser, mon_beat.user);
        checkOutput("beat_grant", grant, mon_exp_grant);
      end
      if (beat_first) first_beat_cyc = cyc_cnt;
      beat_first = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst                   = 1'b1;
    s_hdr_data            = '0;
    s_hdr_valid           = '0;
    s_payload_axis_tdata  = '0;
    s_payload_axis_tkeep  = '0;
    s_payload_axis_tvalid = '0;
    s_payload_axis_tlast  = '0;
    s_payload_axis_tuser  = '0;
    m_usr_hdr_ready       = 1'b1;
    #2;
    checkOutput("rst_grant", grant, 4'b0000);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rr_ptr", dut.rr_ptr, 2'd0);
    checkOutput("rst_valids", {m_usr_hdr_valid, m_usr_payload_axis_tvalid}, 2'b00);
    checkOutput("rst_readies", {s_hdr_ready, s_payload_axis_tready}, 8'h00);
    waitCycles(2);
    rst = 1'b0;
    waitCycles(1);

    $display("[TB] single requester on port 0");
    loadPacket(0, {16'd24, 16'd5000, 16'd1234, 32'hC0A8_0102, 32'hC0A8_0101}, 64'h0);
    data_tbl[0][0] = 64'h0f0f_0f0f_0f0f_0f0f;
    data_tbl[0][1] = 64'h0101_0101_0101_0101;
    expectPacket(0, 2);
    fork
      applyStimulus(0, 2);
      begin
        @(negedge clk);
        checkOutput("t1_hdr_valid_t", m_usr_hdr_valid, 1'b0);
        @(negedge clk);
        checkOutput("t1_hdr_valid_t1", m_usr_hdr_valid, 1'b1);
        checkOutput("t1_grant", grant, 4'b0001);
      end
    join
    @(negedge clk);
    checkOutput("t1_idle1_busy", {busy, grant}, 5'b0_0000);
    @(negedge clk);
    checkOutput("t1_idle2_busy", {busy, grant}, 5'b0_0000);
    checkOutput("t1_rr_ptr", dut.rr_ptr, 2'd1);
    waitCycles(1);

    $display("[TB] ports 0 and 2 together from rr_ptr 0");
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    waitCycles(1);
    loadPacket(0, {16'd16, 16'd80, 16'd1000, 32'h0A00_0001, 32'h0A00_0010}, 64'hA000_0000_0000_0000);
    loadPacket(2, {16'd16, 16'd81, 16'd1002, 32'h0A00_0002, 32'h0A00_0012}, 64'hC000_0000_0000_0000);
    expectPacket(0, 2);
    expectPacket(2, 2);
    fork
      applyStimulus(0, 2);
      applyStimulus(2, 2);
    join
    checkOutput("t2_rr_ptr", dut.rr_ptr, 2'd3);
    waitCycles(1);

    $display("[TB] wrap-around: ports 1 and 3 from rr_ptr 3");
    loadPacket(1, {16'd8, 16'd53, 16'd2001, 32'h0A00_0003, 32'h0A00_0011}, 64'hB000_0000_0000_0000);
    loadPacket(3, {16'd16, 16'd54, 16'd2003, 32'h0A00_0004, 32'h0A00_0013}, 64'hD000_0000_0000_0000);
    expectPacket(3, 2);
    expectPacket(1, 1);
    fork
      applyStimulus(1, 1);
      applyStimulus(3, 2);
    join
    checkOutput("t3_rr_ptr", dut.rr_ptr, 2'd2);
    waitCycles(1);

    $display("[TB] backpressure toggling on a 4-beat packet");
    loadPacket(1, {16'd32, 16'd99, 16'd3001, 32'h0A00_0005, 32'h0A00_0021}, 64'h1111_2222_3333_4440);
    keep_tbl[1][3] = 8'h0f;
    user_tbl[1][3] = 1'b1;
    expectPacket(1, 4);
    bp_toggle = 1'b1;
    applyStimulus(1, 4);
    bp_toggle = 1'b0;
    checkOutput("t4_rr_ptr", dut.rr_ptr, 2'd2);
    waitCycles(2);

    $display("[TB] payload waiting behind a stalled header");
    loadPacket(2, {16'd16, 16'd7, 16'd4002, 32'h0A00_0006, 32'h0A00_0022}, 64'hE000_0000_0000_0100);
    expectPacket(2, 2);
    m_usr_hdr_ready = 1'b0;
    fork
      applyStimulus(2, 2);
      begin
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          checkOutput("t5_payload_ready", s_payload_axis_tready, 4'b0000);
          checkOutput("t5_hdr_valid", m_usr_hdr_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        m_usr_hdr_ready = 1'b1;
      end
    join
    checkOutput("t5_first_beat_gap", first_beat_cyc - last_hdr_cyc, 1);
    checkOutput("t5_rr_ptr", dut.rr_ptr, 2'd3);
    waitCycles(1);

    $display("[TB] reset in the middle of a 3-beat packet");
    loadPacket(0, {16'd24, 16'd11, 16'd5000, 32'h0A00_0007, 32'h0A00_0030}, 64'hF000_0000_0000_0000);
    hdr_exp_t_push: begin
      hdr_exp_t  h;
      beat_exp_t b;
      h.port = 0;
      h.hdr  = hdr_tbl[0];
      hdr_q.push_back(h);
      b.port = 0;
      b.data = data_tbl[0][0];
      b.keep = 8'hff;
      b.last = 1'b0;
      b.user = 1'b0;
      beat_q.push_back(b);
    end
    s_hdr_data[0 +: HW] = hdr_tbl[0];
    s_hdr_valid[0] = 1'b1;
    driveBeat(0, 0, 3);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    s_hdr_valid[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    driveBeat(0, 1, 3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_valids", {m_usr_hdr_valid, m_usr_payload_axis_tvalid}, 2'b00);
    checkOutput("t6_data", m_usr_payload_axis_tdata, 64'd0);
    checkOutput("t6_grant", grant, 4'b0000);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_rr_ptr", dut.rr_ptr, 2'd0);
    checkOutput("t6_payload_ready", s_payload_axis_tready, 4'b0000);
    s_payload_axis_tvalid[0] = 1'b0;
    s_payload_axis_tlast[0]  = 1'b0;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(1);
    loadPacket(1, {16'd16, 16'd12, 16'd6001, 32'h0A00_0008, 32'h0A00_0031}, 64'h5555_0000_0000_0000);
    expectPacket(1, 2);
    fork
      applyStimulus(1, 2);
      begin
        @(negedge clk);
        checkOutput("t6_fresh_valid_t", m_usr_hdr_valid, 1'b0);
        @(negedge clk);
        checkOutput("t6_fresh_valid_t1", m_usr_hdr_valid, 1'b1);
        checkOutput("t6_fresh_grant", grant, 4'b0010);
      end
    join
    checkOutput("t6_fresh_rr_ptr", dut.rr_ptr, 2'd2);

    waitCycles(3);
    checkOutput("leftover_hdrs", hdr_q.size(), 0);
    checkOutput("leftover_beats", beat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/usr_tx_arbiter.md
# usr_tx_arbiter

Packet-granular round-robin arbiter sharing one `fpga_core` user TX pipeline input (`s_usr_hdr_*` + `s_usr_payload_axis_*`) between NUM_PORTS on-board requesters. Each requester presents a 112-bit UDP header `{length, dest_port, source_port, dest_ip, source_ip}` followed by a 64-bit AXI-Stream payload. The grant is held from header acceptance through the payload `tlast` beat, so headers and payloads are never interleaved between requesters.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `HDR_WIDTH`, 112: UDP header width.
- `DATA_WIDTH`, 64: payload width.
- `KEEP_WIDTH`, 8: DATA_WIDTH/8.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `s_hdr_data` in NUM_PORTS*HDR_WIDTH: per-port headers; port i occupies slice i.
- `s_hdr_valid` in NUM_PORTS: per-port header valid.
- `s_hdr_ready` out NUM_PORTS: per-port header ready.
- `s_payload_axis_tdata` in NUM_PORTS*DATA_WIDTH: per-port payload data.
- `s_payload_axis_tkeep` in NUM_PORTS*KEEP_WIDTH: per-port payload keep.
- `s_payload_axis_tvalid` in NUM_PORTS: per-port payload valid.
- `s_payload_axis_tlast` in NUM_PORTS: per-port end of packet.
- `s_payload_axis_tuser` in NUM_PORTS: per-port error flag.
- `s_payload_axis_tready` out NUM_PORTS: per-port payload ready.
- `m_usr_hdr_data` out HDR_WIDTH, `m_usr_hdr_valid` out 1, `m_usr_hdr_ready` in 1: header to `fpga_core`.
- `m_usr_payload_axis_tdata/tkeep/tvalid/tlast/tuser` out DATA_WIDTH/KEEP_WIDTH/1/1/1, `m_usr_payload_axis_tready` in 1: payload to `fpga_core`.
- `grant` out NUM_PORTS: one-hot registered grant; 0 when idle.
- `busy` out 1: high in HDR or PAYLOAD.

## Operation
- FSM states: IDLE, HDR, PAYLOAD. Registers: `state`, `grant`, `rr_ptr` (clog2(NUM_PORTS) bits).
- IDLE: if any `s_hdr_valid`, pick the first set bit searching upward from `rr_ptr` and wrapping modulo NUM_PORTS. Register it into `grant` and go to HDR. No valid header: stay in IDLE with `grant`=0.
- HDR: `m_usr_hdr_data/valid` = granted port's header; `s_hdr_ready[g]` = `m_usr_hdr_ready`. On `m_usr_hdr_valid && m_usr_hdr_ready`, go to PAYLOAD. Payload ready is 0 for all ports in HDR.
- PAYLOAD: granted port's payload fields are muxed to `m_usr_payload_*`; `s_payload_axis_tready[g]` = `m_usr_payload_axis_tready`. On a beat with `tlast`: `rr_ptr` ← (g+1) mod NUM_PORTS, `grant` ← 0, go to IDLE.
- Non-granted ports see ready=0 on both channels at all times. `tuser` is passed through unmodified; the arbiter never drops packets.
- Output data muxes drive 0 when `grant`=0. The mux is combinational from the registered `grant`; the arbiter adds no datapath register.
- Lowering `s_hdr_valid` in IDLE before a grant is legal. Once granted, the requester holds the header until it is accepted (AXIS rule).

## Timing
- Reset, asynchronous: `state`=IDLE, `grant`=0, `rr_ptr`=0, `busy`=0. All `m_*valid`=0, all `s_*ready`=0, all data outputs 0.
- Arbitration latency: header valid in IDLE at cycle t gives `m_usr_hdr_valid` at t+1.
- Inter-packet gap: `tlast` handshake at cycle t, IDLE at t+1, next header presented at t+2.
- Throughput inside a packet: 1 beat/cycle when `m_usr_payload_axis_tready`=1. Ready is combinational from the downstream.
- Single-beat packet (`tlast` on first beat) is legal: HDR → PAYLOAD → IDLE.
- Reset mid-packet: the partial packet is abandoned; the downstream sees valid fall asynchronously.
- Header accepted on the same cycle a payload beat is presented: the beat is not accepted until the next cycle, in PAYLOAD.

## Test plan
- Single requester on port 0: header len=24, two beats 0x0f0f0f0f0f0f0f0f / 0x0101010101010101 (tlast on 2nd) → forwarded unchanged; `grant`=0001 throughout; idle 2 cycles after tlast.
- Ports 0 and 2 assert header in the same cycle with `rr_ptr`=0 → port 0's packet, then port 2's; no interleaved beats; `rr_ptr`=3 after.
- Wrap-around: `rr_ptr`=3, ports 1 and 3 valid → port 3 first, then port 1; `rr_ptr` ends at 2.
- Backpressure: toggle `m_usr_payload_axis_tready` 1/0 every cycle during a 4-beat packet → 4 beats delivered in order, none duplicated or lost; other ports stay at ready=0.
- Payload valid before header accept, `m_usr_hdr_ready` held 0 for 5 cycles → `s_payload_axis_tready`=0 for those cycles; the first beat transfers the cycle after header accept.
- Assert `rst` after beat 1 of 3 → all outputs 0 immediately, `grant`=0, `rr_ptr`=0; after release, a fresh request on port 1 is granted in 1 cycle.
